// File: rtl/systolic_feeder.sv
// Transmit side of the systolic array edge buses: frames tiles, applies the
// diagonal lane skew (lane k delayed k cycles) and drains the skew tail.
module systolic_feeder #(
  parameter int unsigned ARR_SIZE      = 4,
  parameter int unsigned VERTICAL_BW   = 32,
  parameter int unsigned HORIZONTAL_BW = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_mode,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              s_last,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] s_h_data,
  input  logic [VERTICAL_BW*ARR_SIZE-1:0]   s_v_data,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
  output logic [VERTICAL_BW*ARR_SIZE-1:0]   vertical_input,
  output logic [ARR_SIZE-1:0]               o_lane_valid,
  output logic                              o_mode,
  output logic                              o_busy,
  output logic                              o_tile_done
);

  localparam int unsigned CW = $clog2(ARR_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(ARR_SIZE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            accept;

  assign s_ready = (state_q != DRAIN);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = i_mode;
          cnt_d   = '0;
          state_d = s_last ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (accept && s_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign o_mode      = mode_q;
  assign o_busy      = (state_q != IDLE);
  assign o_tile_done = (state_q == DRAIN) && (cnt_q == CNT_LAST);

  // Each lane is a packed shift register: stage 0 in the LSBs, the output
  // stage (stage k) in the MSBs.
  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
    localparam int unsigned HW = (k + 1) * HORIZONTAL_BW;
    localparam int unsigned VW = (k + 1) * VERTICAL_BW;

    logic [HW-1:0]            h_q, h_d;
    logic [VW-1:0]            v_q, v_d;
    logic [k:0]               vld_q, vld_d;
    logic [HORIZONTAL_BW-1:0] h_in;
    logic [VERTICAL_BW-1:0]   v_in;

    always_comb begin
      h_in = '0;
      v_in = '0;
      if (accept) begin
        h_in = s_h_data[k*HORIZONTAL_BW +: HORIZONTAL_BW];
        v_in = s_v_data[k*VERTICAL_BW +: VERTICAL_BW];
      end
    end

    if (k == 0) begin : g_head
      always_comb begin
        h_d   = h_in;
        v_d   = v_in;
        vld_d = accept;
      end
    end else begin : g_tail
      always_comb begin
        h_d   = {h_q[HW-HORIZONTAL_BW-1:0], h_in};
        v_d   = {v_q[VW-VERTICAL_BW-1:0], v_in};
        vld_d = {vld_q[k-1:0], accept};
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        h_q   <= '0;
        v_q   <= '0;
        vld_q <= '0;
      end else begin
        h_q   <= h_d;
        v_q   <= v_d;
        vld_q <= vld_d;
      end
    end

    assign horizontal_input[k*HORIZONTAL_BW +: HORIZONTAL_BW] = h_q[HW-1 -: HORIZONTAL_BW];
    assign vertical_input[k*VERTICAL_BW +: VERTICAL_BW]       = v_q[VW-1 -: VERTICAL_BW];
    assign o_lane_valid[k]                                    = vld_q[k];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: per-lane expected queues are filled
// as beats are driven and popped as each skewed lane presents them.
module tb_systolic_feeder;

  localparam int A  = 4;
  localparam int HB = 16;
  localparam int VB = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_mode = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  logic [HB*A-1:0] s_h_data = '0;
  logic [VB*A-1:0] s_v_data = '0;
  logic [HB*A-1:0] horizontal_input;
  logic [VB*A-1:0] vertical_input;
  logic [A-1:0]    o_lane_valid;
  logic            o_mode;
  logic            o_busy;
  logic            o_tile_done;

  always #5 clk = ~clk;

  systolic_feeder #(
    .ARR_SIZE      (A),
    .VERTICAL_BW   (VB),
    .HORIZONTAL_BW (HB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_mode           (i_mode),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_last           (s_last),
    .s_h_data         (s_h_data),
    .s_v_data         (s_v_data),
    .horizontal_input (horizontal_input),
    .vertical_input   (vertical_input),
    .o_lane_valid     (o_lane_valid),
    .o_mode           (o_mode),
    .o_busy           (o_busy),
    .o_tile_done      (o_tile_done)
  );

  // Entry layout: {valid, vertical element, horizontal element}
  typedef logic [HB+VB:0] ent_t;

  ent_t lane_q[A][$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_state = 0;   // 0 idle, 1 stream, 2 drain
  int   m_cnt = 0;
  logic m_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane k's pipeline holds k older entries ahead of the one just pushed.
  task automatic clear_lanes();
    for (int k = 0; k < A; k++) begin
      lane_q[k].delete();
      for (int j = 0; j < k; j++) lane_q[k].push_back('0);
    end
  endtask

  function automatic logic [HB*A-1:0] mk_h(input int b);
    logic [HB*A-1:0] r;
    for (int k = 0; k < A; k++) r[k*HB +: HB] = 16'(16 * b + k);
    return r;
  endfunction

  function automatic logic [VB*A-1:0] rand_v();
    logic [VB*A-1:0] r;
    for (int k = 0; k < A; k++) r[k*VB +: VB] = $urandom;
    return r;
  endfunction

  task automatic tick(input logic v, input logic l, input logic m, input logic r,
                      input logic [HB*A-1:0] h, input logic [VB*A-1:0] vd);
    logic acc;
    logic m_ready;
    ent_t e;
    ent_t got;
    @(negedge clk);
    rst = r; s_valid = v; s_last = l; i_mode = m; s_h_data = h; s_v_data = vd;
    #1;
    m_ready = (m_state != 2);
    if (r) check_eq("s_ready", 64'(s_ready), 64'(m_ready));
    acc = r && v && m_ready;
    if (!r) begin
      clear_lanes();
      m_state = 0; m_cnt = 0; m_mode = 1'b0;
    end
    for (int k = 0; k < A; k++) begin
      e = acc ? {1'b1, vd[k*VB +: VB], h[k*HB +: HB]} : '0;
      lane_q[k].push_back(e);
    end
    if (r) begin
      case (m_state)
        0: if (acc) begin m_mode = m; m_cnt = 0; m_state = l ? 2 : 1; end
        1: if (acc && l) begin m_cnt = 0; m_state = 2; end
        default: begin
          if (m_cnt == A - 1) begin m_cnt = 0; m_state = 0; end
          else m_cnt++;
        end
      endcase
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < A; k++) begin
      e   = lane_q[k].pop_front();
      got = {o_lane_valid[k], vertical_input[k*VB +: VB], horizontal_input[k*HB +: HB]};
      check_eq($sformatf("lane%0d", k), 64'(got), 64'(e));
    end
    check_eq("tile_done", 64'(o_tile_done), 64'((m_state == 2) && (m_cnt == A - 1)));
    check_eq("busy", 64'(o_busy), 64'(m_state != 0));
    check_eq("mode", 64'(o_mode), 64'(m_mode));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    clear_lanes();
    // reset held with valid asserted
    tick(1'b1, 1'b0, 1'b1, 1'b0, mk_h(7), rand_v());
    tick(1'b1, 1'b0, 1'b1, 1'b0, mk_h(7), rand_v());
    idle(2);
    // single-beat tile
    tick(1'b1, 1'b1, 1'b0, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, rand_v());
    idle(6);
    // four back-to-back beats
    for (int b = 0; b < 4; b++) tick(1'b1, b == 3, 1'b0, 1'b1, mk_h(b), rand_v());
    idle(6);
    // two-cycle gap inside a tile
    tick(1'b1, 1'b0, 1'b1, 1'b1, mk_h(8), rand_v());
    tick(1'b1, 1'b0, 1'b0, 1'b1, mk_h(9), rand_v());
    idle(2);
    tick(1'b1, 1'b1, 1'b0, 1'b1, mk_h(10), rand_v());
    idle(6);
    // reset at DRAIN cnt==1
    tick(1'b1, 1'b1, 1'b1, 1'b1, mk_h(11), rand_v());
    idle(1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(5);
    // mode latch and DRAIN ignoring s_valid
    tick(1'b1, 1'b0, 1'b1, 1'b1, mk_h(12), rand_v());
    tick(1'b1, 1'b1, 1'b0, 1'b1, mk_h(13), rand_v());
    for (int i = 0; i < A; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, mk_h(14 + i), rand_v());
    tick(1'b1, 1'b1, 1'b0, 1'b1, mk_h(3), rand_v());
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
